rsa_modexp_core: RTL and testbench

Parametrised RSA modular-exponentiation engine computing C = M^E mod P with bit-serial Montgomery multiplication. It replaces the fixed 8-bit exponentiation unit behind the SPI/GPIO control path. It keeps the same P/E/M/Const/C register contract and adds:
- generic operand width;
- an optional constant-time schedule;
- abort support;
- even-modulus error reporting.

---
 rtl/rsa_modexp_core.sv | 231 +++++++++++++++++++++++
 tb/tb_rsa_modexp_core.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp_core.sv
// rsa_modexp_core
//   Computes C = M^E mod P using bit-serial Montgomery multiplication.
//   Inputs are mapped into the Montgomery domain with Const = 2^(2*WIDTH) mod P.
//   The exponent is then scanned MSB first, one square per bit and one multiply
//   per set bit. A final multiply by 1 maps the result back out of the domain.
//   With CONST_TIME set, the multiply runs on every exponent bit, and its result
//   is kept only for set bits.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   ena           clock enable; all state holds while low
//   start         begin an operation (accepted in IDLE only, loses to stop)
//   stop          abort a running operation
//   clear         clear C/eoc/err while idle
//   P, E, M       modulus (must be odd), exponent, message
//   Const         Montgomery constant 2^(2*WIDTH) mod P
//   C             registered result
//   busy          operation in progress
//   eoc           sticky end-of-computation flag
//   err           sticky even-modulus flag, valid with eoc
module rsa_modexp_core #(
  parameter int WIDTH      = 8,
  parameter int EXP_WIDTH  = WIDTH,
  parameter int CONST_TIME = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 clear,
  input  logic [WIDTH-1:0]     P,
  input  logic [EXP_WIDTH-1:0] E,
  input  logic [WIDTH-1:0]     M,
  input  logic [WIDTH-1:0]     Const,
  output logic [WIDTH-1:0]     C,
  output logic                 busy,
  output logic                 eoc,
  output logic                 err
);

  localparam int SW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
  localparam logic [IW-1:0] IDX_TOP  = IW'(EXP_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, PRE_M, PRE_X, SQR, MUL, POST, DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SW-1:0]        s_q, s_d;
  logic [WIDTH-1:0]     x_q, x_d;
  logic [WIDTH-1:0]     mbar_q, mbar_d;
  logic [WIDTH-1:0]     p_q, p_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     k_q, k_d;
  logic [EXP_WIDTH-1:0] e_q, e_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [WIDTH-1:0]     c_q, c_d;
  logic                 eoc_q, eoc_d;
  logic                 err_q, err_d;
  logic                 even_q, even_d;

  // Montgomery datapath signals
  logic [WIDTH-1:0]     a_op, b_op;
  logic                 a_bit, e_bit;
  logic [SW-1:0]        s_add, s_odd, s_step;
  logic [WIDTH:0]       s_diff;
  logic [WIDTH-1:0]     mm_res;

  // Operand selection for the multiply that the current state performs
  always_comb begin
    a_op = '0;
    b_op = '0;
    case (state_q)
      PRE_M:   begin a_op = m_q;          b_op = k_q;          end
      PRE_X:   begin a_op = WIDTH'(1);    b_op = k_q;          end
      SQR:     begin a_op = x_q;          b_op = x_q;          end
      MUL:     begin a_op = x_q;          b_op = mbar_q;       end
      POST:    begin a_op = x_q;          b_op = WIDTH'(1);    end
      default: begin a_op = '0;           b_op = '0;           end
    endcase
  end

  assign a_bit  = |(a_op & (WIDTH'(1) << cnt_q));
  assign e_bit  = |(e_q & (EXP_WIDTH'(1) << idx_q));
  assign s_add  = s_q + (a_bit ? {2'b00, b_op} : '0);
  assign s_odd  = s_add + (s_add[0] ? {2'b00, p_q} : '0);
  assign s_step = s_odd >> 1;
  // S < 2P < 2^(WIDTH+1) at the final cycle, so a WIDTH+1 bit difference
  // whose MSB doubles as the borrow is enough for the conditional subtract.
  assign s_diff = s_q[WIDTH:0] - {1'b0, p_q};
  assign mm_res = s_diff[WIDTH] ? s_q[WIDTH-1:0] : s_diff[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    x_d     = x_q;
    mbar_d  = mbar_q;
    p_d     = p_q;
    m_d     = m_q;
    k_d     = k_q;
    e_d     = e_q;
    idx_d   = idx_q;
    c_d     = c_q;
    eoc_d   = eoc_q;
    err_d   = err_q;
    even_d  = even_q;

    if (state_q != IDLE && stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            p_d    = P;
            e_d    = E;
            m_d    = M;
            k_d    = Const;
            idx_d  = IDX_TOP;
            cnt_d  = '0;
            s_d    = '0;
            eoc_d  = 1'b0;
            err_d  = 1'b0;
            even_d = ~P[0];
            // An even modulus skips the arithmetic and reports on the next edge
            state_d = P[0] ? PRE_M : DONE;
          end else if (clear) begin
            c_d   = '0;
            eoc_d = 1'b0;
            err_d = 1'b0;
          end
        end
        DONE: begin
          c_d     = even_q ? '0 : x_q;
          eoc_d   = 1'b1;
          err_d   = even_q;
          state_d = IDLE;
        end
        default: begin
          if (cnt_q != CNT_LAST) begin
            s_d   = s_step;
            cnt_d = cnt_q + 1'b1;
          end else begin
            s_d   = '0;
            cnt_d = '0;
            case (state_q)
              PRE_M: begin
                mbar_d  = mm_res;
                state_d = PRE_X;
              end
              PRE_X: begin
                x_d     = mm_res;
                state_d = SQR;
              end
              SQR: begin
                x_d = mm_res;
                if (e_bit || CONST_TIME != 0) begin
                  state_d = MUL;
                end else if (idx_q == '0) begin
                  state_d = POST;
                end else begin
                  idx_d   = idx_q - 1'b1;
                  state_d = SQR;
                end
              end
              MUL: begin
                if (e_bit) x_d = mm_res;
                if (idx_q == '0) begin
                  state_d = POST;
                end else begin
                  idx_d   = idx_q - 1'b1;
                  state_d = SQR;
                end
              end
              POST: begin
                x_d     = mm_res;
                state_d = DONE;
              end
              default: state_d = IDLE;
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s_q     <= '0;
      x_q     <= '0;
      mbar_q  <= '0;
      p_q     <= '0;
      m_q     <= '0;
      k_q     <= '0;
      e_q     <= '0;
      idx_q   <= '0;
      c_q     <= '0;
      eoc_q   <= 1'b0;
      err_q   <= 1'b0;
      even_q  <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      x_q     <= x_d;
      mbar_q  <= mbar_d;
      p_q     <= p_d;
      m_q     <= m_d;
      k_q     <= k_d;
      e_q     <= e_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      eoc_q   <= eoc_d;
      err_q   <= err_d;
      even_q  <= even_d;
    end
  end

  assign C    = c_q;
  assign busy = (state_q != IDLE);
  assign eoc  = eoc_q;
  assign err  = err_q;

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Testbench for rsa_modexp_core: two instances (CONST_TIME 0 and 1, WIDTH 8).
// Stimulus pushes expected results into per-instance queues; a monitor pops
// and compares on every rising eoc, including latency in enabled edges.
module tb_rsa_modexp_core;

  localparam int NORMAL   = 0;
  localparam int STALL    = 1;
  localparam int POKE     = 2;
  localparam int CLRSTART = 3;
  localparam int BUDGET   = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, ena = 1'b1, stop = 1'b0, clear = 1'b0;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [7:0] P = '0, E = '0, M = '0, Const = '0;
  logic [7:0] c0, c1;
  logic       busy0, busy1, eoc0, eoc1, err0, err1;

  rsa_modexp_core #(.WIDTH(8), .EXP_WIDTH(8), .CONST_TIME(0)) dut0 (
    .clk(clk), .rst(rst), .ena(ena), .start(start0), .stop(stop), .clear(clear),
    .P(P), .E(E), .M(M), .Const(Const),
    .C(c0), .busy(busy0), .eoc(eoc0), .err(err0)
  );

  rsa_modexp_core #(.WIDTH(8), .EXP_WIDTH(8), .CONST_TIME(1)) dut1 (
    .clk(clk), .rst(rst), .ena(ena), .start(start1), .stop(stop), .clear(clear),
    .P(P), .E(E), .M(M), .Const(Const),
    .C(c1), .busy(busy1), .eoc(eoc1), .err(err1)
  );

  typedef struct {
    int c;
    int err;
    int start_edge;
    int lat;
  } exp_t;

  exp_t q[2][$];
  int   total = 0;
  int   bad = 0;
  int   en_cnt = 0;
  int   last_c[2];
  logic eoc_seen0 = 1'b0, eoc_seen1 = 1'b0;

  always @(posedge clk) if (ena) en_cnt++;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  // Reference model: plain modular arithmetic, no Montgomery form
  function automatic int ref_c(input int p, input int e, input int m);
    int r;
    if (p % 2 == 0) return 0;
    r = 1 % p;
    repeat (e) r = (r * m) % p;
    return r;
  endfunction

  function automatic int ref_lat(input int d, input int p, input int e);
    int k;
    if (p % 2 == 0) return 1;
    k = (d == 1) ? 8 : $countones(e);
    return 9 * (3 + 8 + k) + 1;
  endfunction

  function automatic int ref_const(input int p);
    return (p == 0) ? 0 : (65536 % p);
  endfunction

  function automatic int busy_of(input int d);
    return (d == 1) ? int'(busy1) : int'(busy0);
  endfunction

  task automatic set_start(input int d, input logic v);
    if (d == 1) start1 = v; else start0 = v;
  endtask

  task automatic on_eoc(input int d, input int c, input int er);
    exp_t x;
    if (q[d].size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_eoc dut%0d: got eoc=1 with no pending op, want none", d);
    end else begin
      x = q[d].pop_front();
      chk($sformatf("result_c dut%0d", d), c, x.c);
      chk($sformatf("result_err dut%0d", d), er, x.err);
      chk($sformatf("latency dut%0d", d), en_cnt - x.start_edge, x.lat);
    end
  endtask

  always @(negedge clk) begin
    if (eoc0 && !eoc_seen0) on_eoc(0, int'(c0), int'(err0));
    if (eoc1 && !eoc_seen1) on_eoc(1, int'(c1), int'(err1));
    eoc_seen0 = eoc0;
    eoc_seen1 = eoc1;
  end

  task automatic run_op(input int d, input int p, input int e, input int m, input int mode);
    exp_t x;
    int   n;
    @(negedge clk);
    P     = p[7:0];
    E     = e[7:0];
    M     = m[7:0];
    Const = ref_const(p) & 8'hFF;
    ena   = 1'b1;
    if (mode == CLRSTART) clear = 1'b1;
    set_start(d, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(d, 1'b0);
    clear        = 1'b0;
    x.c          = ref_c(p, e, m);
    x.err        = (p % 2 == 0) ? 1 : 0;
    x.start_edge = en_cnt;
    x.lat        = ref_lat(d, p, e);
    q[d].push_back(x);
    last_c[d] = x.c;
    chk("busy_after_start", busy_of(d), 1);
    if (mode == CLRSTART) begin
      chk("eoc_cleared_by_start", int'(eoc0), 0);
      chk("err_cleared_by_start", int'(err0), 0);
    end
    // Operands are latched; scramble the inputs while the run proceeds
    P = 8'($urandom);
    E = 8'($urandom);
    M = 8'($urandom);
    Const = 8'($urandom);
    n = 0;
    while (busy_of(d) == 1 && n < BUDGET) begin
      if (mode == STALL) ena = ($urandom_range(0, 3) != 0);
      if (mode == POKE) set_start(d, n == 20);
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    ena = 1'b1;
    set_start(d, 1'b0);
    chk("done_within_budget", (n < BUDGET) ? 1 : 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    last_c[0] = 0;
    last_c[1] = 0;
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_c", int'(c0), 0);
    chk("reset_busy", int'(busy0), 0);
    chk("reset_eoc", int'(eoc0), 0);
    chk("reset_err", int'(err0), 0);
    rst = 1'b0;

    // Textbook encrypt, plain and with clock-enable stalls
    run_op(0, 187, 7, 88, NORMAL);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    chk("clear_c", int'(c0), 0);
    chk("clear_eoc", int'(eoc0), 0);
    chk("clear_err", int'(err0), 0);
    last_c[0] = 0;
    run_op(0, 187, 7, 88, STALL);

    // Constant-time decrypt and identical latency with E = 1
    run_op(1, 187, 23, 11, NORMAL);
    run_op(1, 187, 1, 11, NORMAL);

    // Boundaries
    run_op(0, 187, 0, 5, NORMAL);
    run_op(0, 187, 5, 0, NORMAL);
    run_op(0, 187, 1, 255, NORMAL);
    run_op(0, 1, 9, 200, NORMAL);

    // Even modulus, then a start that coincides with clear
    run_op(0, 186, 7, 88, NORMAL);
    run_op(0, 187, 7, 88, CLRSTART);

    // Abort at edge 40
    @(negedge clk);
    P = 8'd187; E = 8'd7; M = 8'd88; Const = 8'd86;
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (39) begin
      @(posedge clk);
      @(negedge clk);
    end
    stop = 1'b1;
    @(posedge clk);
    @(negedge clk);
    stop = 1'b0;
    chk("abort_busy", int'(busy0), 0);
    chk("abort_eoc", int'(eoc0), 0);
    chk("abort_c", int'(c0), last_c[0]);

    // Start pulses while busy are ignored
    run_op(0, 187, 7, 88, POKE);

    // start and stop together in IDLE: nothing starts, eoc stays
    @(negedge clk);
    P = 8'd187; E = 8'd7; M = 8'd88; Const = 8'd86;
    start0 = 1'b1;
    stop   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    stop   = 1'b0;
    chk("startstop_busy", int'(busy0), 0);
    chk("startstop_eoc", int'(eoc0), 1);

    // Asynchronous reset at edge 60, then a clean run
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (59) begin
      @(posedge clk);
      @(negedge clk);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", int'(busy0), 0);
    chk("async_rst_c", int'(c0), 0);
    chk("async_rst_eoc", int'(eoc0), 0);
    chk("async_rst_c1", int'(c1), 0);
    @(negedge clk);
    rst = 1'b0;
    last_c[0] = 0;
    last_c[1] = 0;
    run_op(0, 187, 7, 88, NORMAL);

    // Randomized operations on both instances
    for (int i = 0; i < 30; i++) begin
      int p, e, m, mode;
      p    = int'($urandom_range(0, 255)) | (($urandom_range(0, 7) != 0) ? 1 : 0);
      e    = int'($urandom_range(0, 255));
      m    = int'($urandom_range(0, 255));
      mode = ($urandom_range(0, 3) == 0) ? STALL : NORMAL;
      run_op(i % 2, p, e, m, mode);
    end

    repeat (3) @(negedge clk);
    chk("queue0_drained", q[0].size(), 0);
    chk("queue1_drained", q[1].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
